// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Multi-cycle MIPS multiply/divide unit with HI/LO registers,
//               fixed-latency multiplier and 32-step restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StartE,
    input  logic [2:0]  MduOpE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        FlushM,
    input  logic        MduUseD,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        Busy,
    output logic        MduStallD
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MUL     = 2'd1;
    localparam logic [1:0] DIV     = 2'd2;
    localparam logic [1:0] DIV_FIX = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES - 1);

    logic [1:0]  state;
    logic [4:0]  counter;
    logic [31:0] hi, lo;
    logic [31:0] op_a;      // raw dividend / multiplicand
    logic [31:0] op_b;      // multiplier, or divisor magnitude
    logic        mul_signed;
    logic [31:0] quo, rem;
    logic        q_neg, r_neg;

    logic        accept;
    logic        is_signed_op;
    logic [31:0] abs_a, abs_b;
    logic [63:0] ext_a, ext_b, product;
    logic [32:0] partial, diff;

    assign accept       = StartE && !FlushM && (state == IDLE);
    assign is_signed_op = (MduOpE == OP_DIV);
    assign abs_a        = (is_signed_op && SrcAE[31]) ? -SrcAE : SrcAE;
    assign abs_b        = (is_signed_op && SrcBE[31]) ? -SrcBE : SrcBE;

    // Lower 64 bits of the extended product are correct for both signednesses.
    assign ext_a   = mul_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
    assign ext_b   = mul_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
    assign product = ext_a * ext_b;

    assign partial = {rem, quo[31]};
    assign diff    = partial - {1'b0, op_b};

    assign HiOut     = hi;
    assign LoOut     = lo;
    assign Busy      = (state != IDLE);
    assign MduStallD = MduUseD && (Busy || (StartE && !FlushM));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            counter    <= 5'd0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            mul_signed <= 1'b0;
            quo        <= 32'd0;
            rem        <= 32'd0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (MduOpE)
                            OP_MULT, OP_MULTU: begin
                                op_a       <= SrcAE;
                                op_b       <= SrcBE;
                                mul_signed <= (MduOpE == OP_MULT);
                                counter    <= MUL_LOAD;
                                state      <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_a    <= SrcAE;
                                op_b    <= abs_b;
                                quo     <= abs_a;
                                rem     <= 32'd0;
                                q_neg   <= is_signed_op && (SrcAE[31] ^ SrcBE[31]);
                                r_neg   <= is_signed_op && SrcAE[31];
                                counter <= 5'd31;
                                state   <= DIV;
                            end
                            OP_MTHI: hi <= SrcAE;
                            OP_MTLO: lo <= SrcAE;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (counter == 5'd0) begin
                        hi    <= product[63:32];
                        lo    <= product[31:0];
                        state <= IDLE;
                    end else begin
                        counter <= counter - 5'd1;
                    end
                end
                DIV: begin
                    // Restoring step: keep the subtraction only if it did not borrow.
                    if (!diff[32]) begin
                        rem <= diff[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= partial[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                    if (counter == 5'd0) begin
                        state <= DIV_FIX;
                    end else begin
                        counter <= counter - 5'd1;
                    end
                end
                DIV_FIX: begin
                    if (op_b == 32'd0) begin
                        lo <= 32'hFFFF_FFFF;
                        hi <= op_a;
                    end else begin
                        lo <= q_neg ? -quo : quo;
                        hi <= r_neg ? -rem : rem;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
